// File: rtl/nrd_div_core.sv
// Unsigned non-restoring divider core.
// Operands arrive as two input beats (dividend, divisor). One quotient bit is
// produced per clock, followed by a single remainder correction step. Results
// leave as two output beats (quotient, remainder). All outputs are registered.
module nrd_div_core #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_bus,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_bus,
  output logic             out_sel,
  output logic             busy,
  output logic             dbz
);

  localparam int unsigned AW = WIDTH + 1;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_M  = 3'd1,
    RUN     = 3'd2,
    CORRECT = 3'd3,
    OUT_Q   = 3'd4,
    OUT_R   = 3'd5
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] q;
  logic [AW-1:0]    a;
  logic [CW-1:0]    cnt;

  logic [AW-1:0]    m_ext;
  logic [AW-1:0]    a_sh;
  logic [AW-1:0]    a_step;
  logic [AW-1:0]    a_fix;

  // Datapath: one non-restoring step and the final remainder correction.
  // A stays within [-M, M), so modular WIDTH+1 arithmetic is exact.
  always_comb begin
    m_ext  = {1'b0, m};
    a_sh   = {a[WIDTH-1:0], q[WIDTH-1]};
    a_step = a[WIDTH] ? (a_sh + m_ext) : (a_sh - m_ext);
    a_fix  = a[WIDTH] ? (a + m_ext) : a;
  end

  // Sequencer, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      m         <= '0;
      q         <= '0;
      a         <= '0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_bus   <= '0;
      out_sel   <= 1'b0;
      busy      <= 1'b0;
      dbz       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            q     <= in_bus;
            a     <= '0;
            dbz   <= 1'b0;
            busy  <= 1'b1;
            state <= LOAD_M;
          end
        end

        LOAD_M: begin
          if (in_valid) begin
            m        <= in_bus;
            in_ready <= 1'b0;
            if (in_bus == '0) begin
              // Divide by zero: quotient all ones, remainder is the dividend.
              dbz       <= 1'b1;
              a         <= {1'b0, q};
              q         <= '1;
              out_valid <= 1'b1;
              out_bus   <= '1;
              out_sel   <= 1'b0;
              state     <= OUT_Q;
            end else begin
              cnt   <= CW'(WIDTH);
              state <= RUN;
            end
          end
        end

        RUN: begin
          a   <= a_step;
          q   <= {q[WIDTH-2:0], ~a_step[WIDTH]};
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= CORRECT;
          end
        end

        CORRECT: begin
          a         <= a_fix;
          out_valid <= 1'b1;
          out_bus   <= q;
          out_sel   <= 1'b0;
          state     <= OUT_Q;
        end

        OUT_Q: begin
          if (out_ready) begin
            out_bus <= a[WIDTH-1:0];
            out_sel <= 1'b1;
            state   <= OUT_R;
          end
        end

        OUT_R: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_bus   <= '0;
            out_sel   <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          out_bus   <= '0;
          out_sel   <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nrd_div_core.sv
// Bench for nrd_div_core: an 8-bit and a 16-bit instance share one stimulus
// path selected by 'cur'. Expected result beats come from plain / and %.
module tb_nrd_div_core;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cur = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] in_bus = '0;

  always #5 clk = ~clk;

  logic       ir8, ov8, os8, bz8, dz8;
  logic [7:0] ob8;
  logic       ir16, ov16, os16, bz16, dz16;
  logic [15:0] ob16;

  nrd_div_core #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid & ~cur), .in_ready(ir8),
    .in_bus(in_bus[7:0]), .out_valid(ov8), .out_ready(out_ready & ~cur),
    .out_bus(ob8), .out_sel(os8), .busy(bz8), .dbz(dz8)
  );

  nrd_div_core #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid & cur), .in_ready(ir16),
    .in_bus(in_bus), .out_valid(ov16), .out_ready(out_ready & cur),
    .out_bus(ob16), .out_sel(os16), .busy(bz16), .dbz(dz16)
  );

  wire        ir   = cur ? ir16 : ir8;
  wire        ov   = cur ? ov16 : ov8;
  wire        osel = cur ? os16 : os8;
  wire        bsy  = cur ? bz16 : bz8;
  wire        dz   = cur ? dz16 : dz8;
  wire [15:0] ob   = cur ? ob16 : {8'h00, ob8};

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [15:0] v;
    logic        s;
  } beat_t;

  beat_t exp_q[$];
  logic  exp_dbz = 1'b0;
  int    t_div   = 0;
  int    exp_lat = 0;
  logic  ov_prev = 1'b0;
  logic  chk_en  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // Output checker: every cycle, compare the output bus against the model queue.
  always @(negedge clk) begin
    if (rst && chk_en) begin
      if (ov) begin
        if (!ov_prev) check("latency", 32'(cyc - t_div), 32'(exp_lat));
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'(ob), 32'hFFFF_FFFF);
        end else begin
          check("out_bus", 32'(ob), 32'(exp_q[0].v));
          check("out_sel", 32'(osel), 32'(exp_q[0].s));
          check("dbz_out", 32'(dz), 32'(exp_dbz));
          if (out_ready) void'(exp_q.pop_front());
        end
      end else begin
        check("idle_bus", 32'({osel, ob}), 32'h0);
      end
      ov_prev = ov;
    end else begin
      ov_prev = 1'b0;
    end
  end

  // Offer one input beat; returns the cycle index of the transferring edge.
  task automatic send(input logic [15:0] v, output int t);
    int n = 0;
    in_valid = 1'b1;
    in_bus   = v;
    while (!ir && n < 60) begin
      @(posedge clk); #1; n++;
    end
    if (!ir) check("in_ready_timeout", 32'(ir), 32'h1);
    @(posedge clk); #1;
    t        = cyc;
    in_valid = 1'b0;
    in_bus   = '0;
  endtask

  // Full division: send operands, predict results, drain with backpressure.
  task automatic div_op(input logic [15:0] x, input logic [15:0] y, input int bp,
                        input bit junk, input int lq, input int lr);
    int          t;
    int          n;
    logic [15:0] mask;
    logic [15:0] xq, xr;
    beat_t       b;
    mask = cur ? 16'hFFFF : 16'h00FF;
    xq   = (y == 16'h0) ? mask : 16'((x & mask) / y);
    xr   = (y == 16'h0) ? (x & mask) : 16'((x & mask) % y);
    if (lq >= 0) check("model_q", 32'(xq), 32'(lq));
    if (lr >= 0) check("model_r", 32'(xr), 32'(lr));
    check("dbz_before", 32'(dz), 32'(exp_dbz));
    send(x, t);
    check("dbz_clear_ready", 32'({dz, ir, bsy}), 32'b011);
    b.v = xq; b.s = 1'b0; exp_q.push_back(b);
    b.v = xr; b.s = 1'b1; exp_q.push_back(b);
    exp_dbz = (y == 16'h0);
    exp_lat = (y == 16'h0) ? 0 : (cur ? 17 : 9);
    send(y, t);
    t_div = t;
    if (junk) begin
      in_valid = 1'b1;
      in_bus   = 16'h00AA;
    end
    n = 0;
    while (!ov && n < 40) begin
      if (junk) check("run_ir_busy", 32'({ir, bsy}), 32'b01);
      @(posedge clk); #1; n++;
    end
    in_valid = 1'b0;
    in_bus   = '0;
    if (!ov) check("out_valid_timeout", 32'(ov), 32'h1);
    for (int k = 0; k < 2; k++) begin
      repeat (bp) begin
        @(posedge clk); #1;
      end
      if (k == 1) check("outr_ir", 32'(ir), 32'h0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
    check("drained", 32'(exp_q.size()), 32'h0);
    check("back_idle", 32'({ir, bsy, ov}), 32'b100);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(ir), 32'h1);
    check("rst_out_valid", 32'(ov), 32'h0);
    check("rst_out_bus", 32'(ob), 32'h0);
    check("rst_out_sel", 32'(osel), 32'h0);
    check("rst_busy", 32'(bsy), 32'h0);
    check("rst_dbz", 32'(dz), 32'h0);
    rst    = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;

    // WIDTH=8 directed cases
    cur = 1'b0;
    div_op(16'd100, 16'd7, 0, 1'b0, 14, 2);
    div_op(16'd255, 16'd1, 0, 1'b0, 255, 0);
    div_op(16'd5,   16'd9, 0, 1'b0, 0, 5);
    div_op(16'd7,   16'd7, 0, 1'b0, 1, 0);
    div_op(16'd200, 16'd0, 0, 1'b0, 255, 200);
    @(posedge clk); #1;
    check("dbz_hold", 32'(dz), 32'h1);
    div_op(16'd9,   16'd2, 0, 1'b0, 4, 1);

    // Backpressure with ignored input pulses during RUN
    div_op(16'd100, 16'd7, 5, 1'b1, 14, 2);
    div_op(16'd201, 16'd13, 5, 1'b1, 15, 6);

    // Reset abort at RUN step 3
    send(16'd100, t);
    send(16'd7, t);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("abort_in_ready", 32'(ir), 32'h1);
    check("abort_out_valid", 32'(ov), 32'h0);
    check("abort_bus_sel", 32'({osel, ob}), 32'h0);
    check("abort_busy_dbz", 32'({bsy, dz}), 32'h0);
    exp_q.delete();
    exp_dbz = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    div_op(16'd9, 16'd2, 0, 1'b0, 4, 1);

    // WIDTH=16 directed and random sweep
    cur = 1'b1;
    exp_dbz = 1'b0;
    div_op(16'd65535, 16'd255, 0, 1'b0, 257, 0);
    div_op(16'd1000,  16'd33,  2, 1'b0, 30, 10);
    div_op(16'd1234,  16'd0,   0, 1'b0, 65535, 1234);
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] x, y;
      x = 16'($urandom_range(0, 65535));
      if (i % 50 == 7)     y = 16'h0;
      else if (i % 3 == 0) y = 16'($urandom_range(1, 255));
      else                 y = 16'($urandom_range(1, 65535));
      div_op(x, y, (i % 7 == 0) ? 2 : 0, (i % 11 == 0), -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
